// File: rtl/barrel_shift_arb.sv
// barrel_shift_arb: two requesters share one 32-bit right-rotator.
// Round-robin arbitration in IDLE; operands are latched on accept.
// EXEC builds ROR/ROL/SLL/SRL/SRA from the rotator plus masks and sign fill.
// DONE holds a registered result until the consumer handshakes.
module barrel_shift_arb #(
  parameter int WIDTH   = 32,
  parameter int AMT_W   = 5,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ROR = 3'd0;
  localparam logic [2:0] OP_ROL = 3'd1;
  localparam logic [2:0] OP_SLL = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;

  // r_last holds the previous winner; seeding it with the opposite side
  // makes RR_INIT win the first tie after reset.
  localparam logic LAST_INIT = (RR_INIT == 0) ? 1'b1 : 1'b0;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Shared rotator: rotate right by s. A left shift by (0 - s) mod WIDTH
  // covers s = 0 without a shift-by-WIDTH corner case.
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                            input logic [AMT_W-1:0] s);
    return (x >> s) | (x << ({AMT_W{1'b0}} - s));
  endfunction

  logic [1:0]       r_state;
  logic             r_last;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;
  logic             r_id;
  logic             r_res_valid;
  logic             r_res_id;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_err;

  logic             w_gnt0;
  logic             w_gnt1;
  logic [AMT_W-1:0] w_rot_sel;
  logic [WIDTH-1:0] w_rotated;
  logic [WIDTH-1:0] w_srl_mask;
  logic [WIDTH-1:0] w_result;
  logic             w_err;

  // Grant: only in IDLE and never under reset; on a tie the side that did not win last goes.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        if (r_last == 1'b0) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = 1'b1;
        end
      end else if (req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Rotator select: left-going ops rotate right by the two's complement of amt.
  always_comb begin
    w_rot_sel = r_amt;
    case (r_op)
      OP_ROL, OP_SLL:         w_rot_sel = {AMT_W{1'b0}} - r_amt;
      OP_ROR, OP_SRL, OP_SRA: w_rot_sel = r_amt;
      default:                w_rot_sel = r_amt;
    endcase
  end

  assign w_rotated  = rotr(r_data, w_rot_sel);
  assign w_srl_mask = ALL_ONES >> r_amt;

  // Result shaping: mask off wrapped bits for shifts, sign-fill for SRA, flag illegal ops.
  always_comb begin
    w_result = {WIDTH{1'b0}};
    w_err    = 1'b0;
    case (r_op)
      OP_ROR, OP_ROL: w_result = w_rotated;
      OP_SLL:         w_result = w_rotated & (ALL_ONES << r_amt);
      OP_SRL:         w_result = w_rotated & w_srl_mask;
      OP_SRA:         w_result = (w_rotated & w_srl_mask) |
                                 (r_data[WIDTH-1] ? ~w_srl_mask : {WIDTH{1'b0}});
      default: begin
        w_result = {WIDTH{1'b0}};
        w_err    = 1'b1;
      end
    endcase
  end

  // Control FSM, operand latches and registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= LAST_INIT;
      r_op        <= 3'd0;
      r_data      <= {WIDTH{1'b0}};
      r_amt       <= {AMT_W{1'b0}};
      r_id        <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_data  <= {WIDTH{1'b0}};
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_op    <= w_gnt1 ? req1_op   : req0_op;
            r_data  <= w_gnt1 ? req1_data : req0_data;
            r_amt   <= w_gnt1 ? req1_amt  : req0_amt;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_data  <= w_result;
          r_res_err   <= w_err;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Self-checking bench for barrel_shift_arb: directed vectors plus randomized
// traffic compared against a behavioural reference model.
module tb_barrel_shift_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_amt, req1_amt;
  logic        res_valid, res_ready, res_id, res_err;
  logic [31:0] res_data;

  always #5 clk = ~clk;

  barrel_shift_arb #(.WIDTH(32), .AMT_W(5), .RR_INIT(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_amt(req1_amt),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_err(res_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    bit          has_exp;
    logic [31:0] exp;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];
  bit   id_log[$];

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int          m_phase;    // 0 idle, 1 computing, 2 result held
  bit          m_last;     // previous winner
  logic [31:0] m_data;
  bit          m_err;
  bit          m_id;
  int          rdy_mode;   // 0 always ready, 1 random, 2 stall 5 cycles per result
  int          hold_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shifts expressed directly with SV arithmetic operators.
  function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] d, input int a);
    logic [63:0] t;
    case (op)
      3'd0: begin t = {d, d} >> a; return t[31:0]; end
      3'd1: begin t = {d, d} << a; return t[63:32]; end
      3'd2: return d << a;
      3'd3: return d >> a;
      3'd4: return $unsigned($signed(d) >>> a);
      default: return 32'd0;
    endcase
  endfunction

  function automatic cmd_t mk(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                              input bit has, input logic [31:0] e);
    cmd_t c;
    c.op = op; c.data = d; c.amt = a; c.has_exp = has; c.exp = e;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    logic [2:0] op;
    logic [4:0] a;
    op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
    case ($urandom_range(0, 3))
      0: a = 5'd0;
      1: a = 5'd31;
      default: a = 5'($urandom_range(0, 31));
    endcase
    return mk(op, $urandom, a, 1'b0, 32'd0);
  endfunction

  task automatic model_init();
    m_phase  = 0;
    m_last   = 1'b1;   // so requester 0 (RR_INIT) takes the first tie
    hold_cnt = 0;
  endtask

  // One clock: drive at negedge, check shortly after, advance the model.
  task automatic step();
    bit   g0, g1;
    cmd_t c;
    @(negedge clk);
    if (q0.size() > 0) begin
      c = q0[0];
      req0_valid = 1'b1; req0_op = c.op; req0_data = c.data; req0_amt = c.amt;
    end else begin
      req0_valid = 1'b0; req0_op = 3'($urandom); req0_data = $urandom; req0_amt = 5'($urandom);
    end
    if (q1.size() > 0) begin
      c = q1[0];
      req1_valid = 1'b1; req1_op = c.op; req1_data = c.data; req1_amt = c.amt;
    end else begin
      req1_valid = 1'b0; req1_op = 3'($urandom); req1_data = $urandom; req1_amt = 5'($urandom);
    end
    case (rdy_mode)
      1: res_ready = 1'($urandom_range(0, 1));
      2: begin
        if (m_phase == 2 && hold_cnt < 5) begin
          res_ready = 1'b0;
          hold_cnt++;
        end else begin
          res_ready = 1'b1;
        end
      end
      default: res_ready = 1'b1;
    endcase
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (m_phase == 0) begin
      if (req0_valid && req1_valid) begin
        g0 = (m_last == 1'b1);
        g1 = !g0;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    check_eq("req0_ready", 32'(req0_ready), 32'(g0));
    check_eq("req1_ready", 32'(req1_ready), 32'(g1));
    check_eq("res_valid", 32'(res_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check_eq("res_data", res_data, m_data);
      check_eq("res_id", 32'(res_id), 32'(m_id));
      check_eq("res_err", 32'(res_err), 32'(m_err));
    end
    case (m_phase)
      0: begin
        if (g0 || g1) begin
          c = g0 ? q0.pop_front() : q1.pop_front();
          m_id   = g1;
          m_last = g1;
          m_err  = (c.op > 3'd4);
          m_data = c.has_exp ? c.exp : ref_calc(c.op, c.data, int'(c.amt));
          id_log.push_back(g1);
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      default: begin
        if (res_ready) begin
          m_phase  = 0;
          hold_cnt = 0;
        end
      end
    endcase
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_phase != 0) && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("drain_done", 32'(q0.size() == 0 && q1.size() == 0 && m_phase == 0), 32'd1);
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_data", res_data, 32'd0);
    check_eq("rst_res_id", 32'(res_id), 32'd0);
    check_eq("rst_res_err", 32'(res_err), 32'd0);
    check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("rst_req1_ready", 32'(req1_ready), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    q0.delete();
    q1.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_init();
    reset = 1'b0;
  endtask

  task automatic run_to_phase(input int ph);
    int n = 0;
    while (m_phase != ph && n < 20) begin
      step();
      n++;
    end
    check_eq("reach_phase", 32'(m_phase), 32'(ph));
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_data = 32'd0; req0_amt = 5'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_data = 32'd0; req1_amt = 5'd0;
    res_ready = 1'b1;
    rdy_mode = 0;
    model_init();
    hit_reset();
    repeat (2) @(negedge clk);
    release_reset();

    // single ROR on requester 0
    q0.push_back(mk(3'd0, 32'h12345678, 5'd16, 1'b1, 32'h56781234));
    drain(20);

    // requester 1 directed vectors, then amt=0 for every legal op
    q1.push_back(mk(3'd1, 32'h80000001, 5'd1,  1'b1, 32'h00000003));
    q1.push_back(mk(3'd2, 32'h000000FF, 5'd8,  1'b1, 32'h0000FF00));
    q1.push_back(mk(3'd3, 32'hF0000000, 5'd28, 1'b1, 32'h0000000F));
    q1.push_back(mk(3'd4, 32'h80000000, 5'd4,  1'b1, 32'hF8000000));
    q1.push_back(mk(3'd4, 32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000));
    for (int i = 0; i < 5; i++) q1.push_back(mk(3'(i), 32'hA5C31E69, 5'd0, 1'b1, 32'hA5C31E69));
    drain(100);

    // alternation with both requesters continuously valid
    hit_reset();
    release_reset();
    id_log.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rnd_cmd());
      q1.push_back(rnd_cmd());
    end
    drain(60);
    check_eq("rr_count", 32'(id_log.size()), 32'd6);
    for (int i = 0; i < id_log.size(); i++) check_eq("rr_order", 32'(id_log[i]), 32'(i % 2));

    // consumer stalls 5 cycles per result
    rdy_mode = 2;
    q0.push_back(mk(3'd2, 32'hDEADBEEF, 5'd4, 1'b0, 32'd0));
    q1.push_back(mk(3'd4, 32'h9000F00F, 5'd7, 1'b0, 32'd0));
    drain(60);
    rdy_mode = 0;

    // illegal op followed by a legal one
    q0.push_back(mk(3'd6, 32'hFFFFFFFF, 5'd3, 1'b1, 32'h00000000));
    q0.push_back(mk(3'd3, 32'hFFFFFFFF, 5'd3, 1'b1, 32'h1FFFFFFF));
    drain(20);

    // reset during EXEC, then a lone req1 must be granted immediately
    q0.push_back(rnd_cmd());
    run_to_phase(1);
    @(posedge clk);
    #2;
    hit_reset();
    release_reset();
    q1.push_back(mk(3'd0, 32'h0000000F, 5'd4, 1'b1, 32'hF0000000));
    drain(20);

    // reset during DONE, then first tie goes to requester 0 again
    q1.push_back(rnd_cmd());
    run_to_phase(2);
    @(posedge clk);
    #2;
    check_eq("pre_rst_valid", 32'(res_valid), 32'd1);
    hit_reset();
    release_reset();
    id_log.delete();
    q0.push_back(rnd_cmd());
    q1.push_back(rnd_cmd());
    drain(20);
    check_eq("post_rst_first", 32'(id_log[0]), 32'd0);
    check_eq("post_rst_second", 32'(id_log[1]), 32'd1);

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rnd_cmd());
      if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rnd_cmd());
      step();
    end
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
